ensemble_frame_scheduler: RTL and testbench
===========================================

Name: ensemble_frame_scheduler

Overview:
- Sequences one spectrum frame into the bin-ratio spiking-net ensemble.
- Accepts a frame request, pulses trans_start, then streams NUM_BINS histogram bin counts from an external 1-cycle-latency buffer, one bin per cycle.
- Waits for the ensemble's inference-ready pulse, with a timeout, and returns the winning label over a valid/ready result handshake.
- Sits between the histogram buffer and the ensemble top level.

Parameters:
- NUM_BINS, 1024, bins streamed per frame (>=2).
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= NUM_BINS.
- CNT_W, 20, bin count width.
- LABEL_W, 5, class label width.
- TIMEOUT, 65535, maximum cycles spent in WAIT_INFER (>=1).
- TO_W, 16, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_valid  in  1  a frame is ready in the buffer.
- frame_ready  out  1  scheduler can accept a frame.
- mem_rd_en  out  1  buffer read strobe.
- mem_rd_addr  out  ADDR_W  buffer read address.
- mem_rd_data  in  CNT_W  read data, valid exactly 1 cycle after mem_rd_en.
- trans_start  out  1  one-cycle frame-start pulse to the ensemble.
- bin_cnt  out  CNT_W  bin count to the ensemble.
- ens_infer_ready  in  1  ensemble inference-done pulse.
- ens_winner  in  LABEL_W  ensemble final winner; valid while ens_infer_ready=1.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_label  out  LABEL_W  classified label.
- result_timeout  out  1  the result was produced by timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; frame_ready=1 in IDLE, all other outputs 0. result_label=0, mem_rd_addr=0, counters 0.
- Reset asserted mid-frame aborts immediately; there is no residual stream or result.
- States: IDLE, STREAM, FLUSH, WAIT_INFER, RESULT.
- IDLE:
  - frame_ready=1.
  - frame_valid=1 on cycle T: at T+1 trans_start=1 and mem_rd_en=1 with address 0; state goes to STREAM.
  - trans_start is a single-cycle pulse and coincides with the read of address 0.
- STREAM:
  - mem_rd_en=1 every cycle; address increments by 1 per cycle.
  - Address NUM_BINS-1 is read on cycle T+NUM_BINS, then state goes to FLUSH.
  - No stalls and no gaps.
- bin_cnt timing:
  - bin_cnt = mem_rd_data during the data phase (cycles T+2 .. T+NUM_BINS+1), 0 otherwise. It is a combinational pass-through gated by a registered phase flag.
  - Bin k appears exactly (k+1) cycles after the trans_start pulse.
- FLUSH: one cycle. The last bin is presented; mem_rd_en=0. Then state goes to WAIT_INFER and the timeout counter is cleared.
- WAIT_INFER:
  - ens_infer_ready=1: capture ens_winner into result_label, result_timeout=0, go to RESULT.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without ens_infer_ready: result_label all-ones, result_timeout=1, go to RESULT.
  - If ens_infer_ready arrives in the same cycle the counter reaches TIMEOUT-1, the real winner wins and result_timeout=0.
- ens_infer_ready during IDLE, STREAM, FLUSH or RESULT is ignored; it is not latched.
- RESULT:
  - result_valid=1; result_label and result_timeout are held stable until result_ready=1.
  - Handshake cycle: result_valid drops next cycle and state goes to IDLE.
  - result_label keeps its value until the next capture.
- frame_ready=0 outside IDLE. A new frame is accepted at the earliest one cycle after the result handshake; frame_valid is ignored while busy.
- frame_valid may stay high continuously; each acceptance starts exactly one frame.

Optional Feature:
- Macro: ENSEMBLE_SCHED_PERF_CNT_EN.
- Defined:
  - Adds output frames_done [15:0]: increments on every result handshake, wraps at 0xFFFF->0.
  - Adds output last_latency [TO_W-1:0]: number of WAIT_INFER cycles of the last frame, updated at the RESULT entry.
  - Both reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- NUM_BINS=8, buffer holds data[k]=k+100; frame_valid pulse at cycle 0.
  -> trans_start at cycle 1 only; bin_cnt = 100..107 on cycles 2..9; bin_cnt=0 on cycles 10+; mem_rd_en high on cycles 1..8 only.
- Same setup; ens_infer_ready with ens_winner=5'd13 five cycles after FLUSH.
  -> result_valid=1, result_label=13, result_timeout=0; with result_ready held low for 4 cycles, the outputs stay stable; after the handshake, frame_ready=1 on the next cycle.
- TIMEOUT=20; no ens_infer_ready arrives.
  -> 20 cycles after WAIT_INFER entry: result_label=5'h1F, result_timeout=1.
- TIMEOUT=20; ens_infer_ready with winner 7 in the final counted cycle.
  -> result_label=7, result_timeout=0.
- rst_n pulsed low during STREAM at bin 4.
  -> all outputs 0 asynchronously; frame_ready=1 after release; the next frame restarts at address 0.
- frame_valid held high, ens_infer_ready pulse during STREAM, result_ready always 1.
  -> the stray pulse is ignored; back-to-back frames are separated by exactly one IDLE cycle; with PERF_CNT_EN, frames_done counts 1, 2, 3.

Source files
------------

// File: rtl/ensemble_frame_scheduler_if.sv
// Handshake and bus bundle between the histogram buffer, the frame scheduler and the ensemble.
// master = scheduler view, slave = surrounding-system view.
interface ensemble_frame_scheduler_if #(
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 20,
  parameter int LABEL_W = 5
);
  logic               frame_valid;
  logic               frame_ready;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic [CNT_W-1:0]   mem_rd_data;
  logic               trans_start;
  logic [CNT_W-1:0]   bin_cnt;
  logic               ens_infer_ready;
  logic [LABEL_W-1:0] ens_winner;
  logic               result_valid;
  logic               result_ready;
  logic [LABEL_W-1:0] result_label;
  logic               result_timeout;
  logic               busy;

  modport master (
    input  frame_valid, mem_rd_data, ens_infer_ready, ens_winner, result_ready,
    output frame_ready, mem_rd_en, mem_rd_addr, trans_start, bin_cnt,
           result_valid, result_label, result_timeout, busy
  );

  modport slave (
    output frame_valid, mem_rd_data, ens_infer_ready, ens_winner, result_ready,
    input  frame_ready, mem_rd_en, mem_rd_addr, trans_start, bin_cnt,
           result_valid, result_label, result_timeout, busy
  );
endinterface

// File: rtl/ensemble_frame_scheduler.sv
// Streams one histogram frame into the spiking-net ensemble and returns the winning label.
// Optional performance counters are enabled with `define ENSEMBLE_SCHED_PERF_CNT_EN.
module ensemble_frame_scheduler #(
  parameter int NUM_BINS = 1024,
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 20,
  parameter int LABEL_W  = 5,
  parameter int TIMEOUT  = 65535,
  parameter int TO_W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  ensemble_frame_scheduler_if.master bus
`ifdef ENSEMBLE_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]     frames_done,
  output logic [TO_W-1:0] last_latency
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_FLUSH, S_WAIT_INFER, S_RESULT} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_p0;
  logic               trans_start_p0;
  logic               data_vld_p1;
  logic [TO_W-1:0]    to_cnt;
  logic [LABEL_W-1:0] label_q;
  logic               timeout_q;
  logic               to_expired;

  assign to_expired = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (bus.frame_valid) state_nxt = S_STREAM;
      S_STREAM:     if (addr_p0 == LAST_ADDR) state_nxt = S_FLUSH;
      S_FLUSH:      state_nxt = S_WAIT_INFER;
      S_WAIT_INFER: if (bus.ens_infer_ready || to_expired) state_nxt = S_RESULT;
      S_RESULT:     if (bus.result_ready) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: read issue; p1: buffer data returns one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0        <= '0;
      trans_start_p0 <= 1'b0;
      data_vld_p1    <= 1'b0;
    end else begin
      trans_start_p0 <= (state == S_IDLE) && bus.frame_valid;
      data_vld_p1    <= (state == S_STREAM);
      addr_p0        <= ((state == S_STREAM) && (addr_p0 != LAST_ADDR)) ? addr_p0 + 1'b1 : '0;
    end
  end

  // Inference wait: the real winner takes priority over an expiring timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      label_q   <= '0;
      timeout_q <= 1'b0;
    end else if (state == S_FLUSH) begin
      to_cnt <= '0;
    end else if (state == S_WAIT_INFER) begin
      if (bus.ens_infer_ready) begin
        label_q   <= bus.ens_winner;
        timeout_q <= 1'b0;
      end else if (to_expired) begin
        label_q   <= '1;
        timeout_q <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

`ifdef ENSEMBLE_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_done  <= '0;
      last_latency <= '0;
    end else begin
      if ((state == S_RESULT) && bus.result_ready)
        frames_done <= frames_done + 16'd1;
      if ((state == S_WAIT_INFER) && (bus.ens_infer_ready || to_expired))
        last_latency <= to_cnt + 1'b1;
    end
  end
`endif

  assign bus.frame_ready    = (state == S_IDLE);
  assign bus.busy           = (state != S_IDLE);
  assign bus.mem_rd_en      = (state == S_STREAM);
  assign bus.mem_rd_addr    = addr_p0;
  assign bus.trans_start    = trans_start_p0;
  assign bus.bin_cnt        = data_vld_p1 ? bus.mem_rd_data : '0;
  assign bus.result_valid   = (state == S_RESULT);
  assign bus.result_label   = label_q;
  assign bus.result_timeout = timeout_q;

endmodule

// File: tb/tb_ensemble_frame_scheduler.sv
// Directed bench for ensemble_frame_scheduler: NUM_BINS=8, TIMEOUT=20, buffer data[k]=k+100.
module tb_ensemble_frame_scheduler;
  localparam int NUM_BINS = 8;
  localparam int ADDR_W   = 3;
  localparam int CNT_W    = 20;
  localparam int LABEL_W  = 5;
  localparam int TIMEOUT  = 20;
  localparam int TO_W     = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ensemble_frame_scheduler_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .LABEL_W(LABEL_W)) bus ();

`ifdef ENSEMBLE_SCHED_PERF_CNT_EN
  logic [15:0]     frames_done;
  logic [TO_W-1:0] last_latency;
`endif

  ensemble_frame_scheduler #(
    .NUM_BINS(NUM_BINS), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .LABEL_W(LABEL_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef ENSEMBLE_SCHED_PERF_CNT_EN
    ,
    .frames_done  (frames_done),
    .last_latency (last_latency)
`endif
  );

  always #5 clk = ~clk;

  // 1-cycle-latency histogram buffer
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= CNT_W'(100) + CNT_W'(bus.mem_rd_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.frame_valid     = 1'b0;
    bus.ens_infer_ready = 1'b0;
    bus.ens_winner      = '0;
    bus.result_ready    = 1'b0;
    bus.mem_rd_data     = '0;
    #2;
    check("rst_frame_ready", 32'(bus.frame_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_mem_rd_en", 32'(bus.mem_rd_en), 0);
    check("rst_addr", 32'(bus.mem_rd_addr), 0);
    check("rst_trans_start", 32'(bus.trans_start), 0);
    check("rst_result_valid", 32'(bus.result_valid), 0);
    check("rst_label", 32'(bus.result_label), 0);
    check("rst_timeout", 32'(bus.result_timeout), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Frame A: streaming timing, winner 13 five cycles after FLUSH, held result
    bus.frame_valid = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      bus.frame_valid = 1'b0;
      check($sformatf("A_trans_start_c%0d", c), 32'(bus.trans_start), (c == 1) ? 1 : 0);
      check($sformatf("A_rd_en_c%0d", c), 32'(bus.mem_rd_en), (c <= 8) ? 1 : 0);
      check($sformatf("A_bin_cnt_c%0d", c), 32'(bus.bin_cnt), (c >= 2 && c <= 9) ? 100 + c - 2 : 0);
      if (c <= 8) check($sformatf("A_addr_c%0d", c), 32'(bus.mem_rd_addr), c - 1);
      check($sformatf("A_busy_c%0d", c), 32'(bus.busy), 1);
      if (c == 14) begin
        bus.ens_infer_ready = 1'b1;
        bus.ens_winner      = 5'd13;
      end
    end
    tick();
    bus.ens_infer_ready = 1'b0;
    bus.ens_winner      = '0;
    check("A_result_valid", 32'(bus.result_valid), 1);
    check("A_label", 32'(bus.result_label), 13);
    check("A_timeout", 32'(bus.result_timeout), 0);
    check("A_frame_ready_busy", 32'(bus.frame_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("A_hold_valid_%0d", i), 32'(bus.result_valid), 1);
      check($sformatf("A_hold_label_%0d", i), 32'(bus.result_label), 13);
      check($sformatf("A_hold_timeout_%0d", i), 32'(bus.result_timeout), 0);
    end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("A_post_valid", 32'(bus.result_valid), 0);
    check("A_post_frame_ready", 32'(bus.frame_ready), 1);
    check("A_post_label_kept", 32'(bus.result_label), 13);

    // Frame B: no inference pulse, timeout after 20 WAIT_INFER cycles
    bus.frame_valid = 1'b1;
    for (int c = 1; c <= 29; c++) begin
      tick();
      bus.frame_valid = 1'b0;
    end
    check("B_not_yet_valid", 32'(bus.result_valid), 0);
    tick();
    check("B_result_valid", 32'(bus.result_valid), 1);
    check("B_label", 32'(bus.result_label), 32'h1F);
    check("B_timeout", 32'(bus.result_timeout), 1);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;

    // Frame C: winner 7 arrives in the final counted cycle
    bus.frame_valid = 1'b1;
    for (int c = 1; c <= 29; c++) begin
      tick();
      bus.frame_valid = 1'b0;
      if (c == 29) begin
        bus.ens_infer_ready = 1'b1;
        bus.ens_winner      = 5'd7;
      end
    end
    tick();
    bus.ens_infer_ready = 1'b0;
    check("C_result_valid", 32'(bus.result_valid), 1);
    check("C_label", 32'(bus.result_label), 7);
    check("C_timeout", 32'(bus.result_timeout), 0);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;

    // Frame D: asynchronous reset at bin 4, then restart from address 0
    bus.frame_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.frame_valid = 1'b0;
    end
    check("D_addr_before_rst", 32'(bus.mem_rd_addr), 4);
    rst_n = 1'b0;
    #1;
    check("D_rst_rd_en", 32'(bus.mem_rd_en), 0);
    check("D_rst_addr", 32'(bus.mem_rd_addr), 0);
    check("D_rst_bin_cnt", 32'(bus.bin_cnt), 0);
    check("D_rst_busy", 32'(bus.busy), 0);
    check("D_rst_label", 32'(bus.result_label), 0);
    check("D_rst_valid", 32'(bus.result_valid), 0);
    #3;
    rst_n = 1'b1;
    tick();
    check("D_frame_ready", 32'(bus.frame_ready), 1);
    check("D_bin_cnt_idle", 32'(bus.bin_cnt), 0);
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    check("D_restart_addr", 32'(bus.mem_rd_addr), 0);
    check("D_restart_trans_start", 32'(bus.trans_start), 1);
    tick();
    check("D_restart_bin0", 32'(bus.bin_cnt), 100);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();

    // Frames E: frame_valid held, stray pulse during STREAM, result_ready always high
    bus.frame_valid  = 1'b1;
    bus.result_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      check($sformatf("E%0d_idle_frame_ready", f), 32'(bus.frame_ready), 1);
      for (int c = 1; c <= 13; c++) begin
        tick();
        bus.ens_infer_ready = 1'b0;
        if (c == 1) begin
          check($sformatf("E%0d_trans_start", f), 32'(bus.trans_start), 1);
          check($sformatf("E%0d_frame_ready_low", f), 32'(bus.frame_ready), 0);
        end
        if (c == 3) begin
          bus.ens_infer_ready = 1'b1;
          bus.ens_winner      = 5'd9;
        end
        if (c == 10) begin
          check($sformatf("E%0d_stray_ignored", f), 32'(bus.result_valid), 0);
          check($sformatf("E%0d_busy_wait", f), 32'(bus.busy), 1);
        end
        if (c == 12) begin
          bus.ens_infer_ready = 1'b1;
          bus.ens_winner      = 5'(f + 3);
        end
        if (c == 13) begin
          check($sformatf("E%0d_result_valid", f), 32'(bus.result_valid), 1);
          check($sformatf("E%0d_label", f), 32'(bus.result_label), f + 3);
        end
      end
      tick();
      check($sformatf("E%0d_gap_valid", f), 32'(bus.result_valid), 0);
`ifdef ENSEMBLE_SCHED_PERF_CNT_EN
      check($sformatf("E%0d_frames_done", f), 32'(frames_done), f + 1);
      check($sformatf("E%0d_last_latency", f), 32'(last_latency), 3);
`endif
    end
    bus.frame_valid  = 1'b0;
    bus.result_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
